cmac_rx_frame_check: RTL and testbench
======================================

CMAC_RX_FRAME_CHECK -- requirements
Module: cmac_rx_frame_check

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, AXI stream data width in bits; only 512 is legal, any other value is an elaboration error.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width; KEEP_WIDTH*8 != DATA_WIDTH is an elaboration error.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width; bit 0 is the bad-frame flag.
REQ-004 SHALL have parameter MIN_LEN, default 64, minimum legal frame length in bytes.
REQ-005 SHALL have parameter MAX_LEN, default 9600, maximum legal frame length in bytes (max 65535).
REQ-006 SHALL have parameter CNT_WIDTH, default 32, statistics counter width.
REQ-007 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-008 SHALL have ports: s_axis_tdata in DATA_WIDTH; s_axis_tkeep in KEEP_WIDTH; s_axis_tvalid in 1; s_axis_tlast in 1; s_axis_tuser in USER_WIDTH -- CMAC RX stream, no tready.
REQ-009 SHALL have ports: m_axis_tdata out DATA_WIDTH; m_axis_tkeep out KEEP_WIDTH; m_axis_tvalid out 1; m_axis_tlast out 1; m_axis_tuser out USER_WIDTH -- checked stream, no tready.
REQ-010 SHALL have ports: stat_good out 1, stat_runt out 1, stat_oversize out 1, stat_err out 1 (one-cycle pulses); frame_count out CNT_WIDTH; bad_count out CNT_WIDTH.

Function
REQ-011 Only one clock domain (clk); all state updates on rising clk edge; one input beat accepted every cycle s_axis_tvalid=1.
REQ-012 Latency exactly 1 cycle: each emitted beat appears on m_axis_* the cycle after its input beat; m_axis_tvalid=0 in cycles with no emitted beat.
REQ-013 Output tdata byte k = input byte k when tkeep[k]=1, else 8'h00; m_axis_tkeep = s_axis_tkeep.
REQ-014 FSM states: IDLE (no frame open), FRAME (frame open), DROP (oversize frame truncated, discarding to tlast).
REQ-015 len register 16 bits, cleared entering FRAME; beat_bytes = popcount(s_axis_tkeep) (0..64); new_len = len + beat_bytes computed 17 bits wide, no wrap.
REQ-016 IDLE or FRAME, valid beat: if new_len > MAX_LEN -> emit beat with tlast=1, tuser[0]=1, pulse stat_oversize; next state IDLE if s_axis_tlast=1, else DROP.
REQ-017 IDLE or FRAME, valid beat, new_len <= MAX_LEN, tlast=0 -> emit beat, tlast=0, tuser[0]=0, len<=new_len, state FRAME.
REQ-018 IDLE or FRAME, valid beat, new_len <= MAX_LEN, tlast=1 -> emit beat, tlast=1; bad = (new_len < MIN_LEN) | s_axis_tuser[0] | err_seen; tuser[0]=bad; state IDLE.
REQ-019 err_seen sets on any non-last beat with tkeep != all-ones, or with s_axis_tuser[0]=1; cleared on frame end.
REQ-020 On last beat: stat_runt pulses if new_len < MIN_LEN; stat_err pulses if s_axis_tuser[0]|err_seen; stat_good pulses if not bad; pulses coincide with the emitted tlast beat.
REQ-021 DROP: valid beats not emitted (m_axis_tvalid=0); tlast=1 returns to IDLE; no stat pulse.
REQ-022 frame_count increments by 1 per emitted tlast beat; bad_count increments per emitted tlast beat with tuser[0]=1; both saturate at all-ones.
REQ-023 Boundaries: new_len == MAX_LEN is legal; new_len == MIN_LEN is not a runt; tkeep=0 beat adds 0 bytes.
REQ-024 m_axis_tuser bits above bit 0 pass from the input beat unchanged.

Reset
REQ-025 rst=1: state IDLE; len, err_seen = 0; m_axis_tvalid, tlast, tuser, tdata, tkeep = 0; all stat pulses = 0; frame_count, bad_count = 0.
REQ-026 rst mid-frame: partial frame discarded without tlast emitted; first valid beat after rst deasserts starts a new frame.

Verification
REQ-027 Single beat tkeep=64'hFFFF_FFFF_FFFF_FFFF, tlast=1, tuser=0 -> next cycle m_axis_tvalid=1, tlast=1, tuser=0, stat_good=1, frame_count=1.
REQ-028 Single beat tkeep=64'h0000_0000_0000_003C (4 bytes), tlast=1 -> output tuser=1, stat_runt=1, bad_count=1; masked bytes 0-1, 6-63 = 0.
REQ-029 MAX_LEN=128: beats of 64,64 bytes, tlast on 2nd -> good; repeat with 3 beats -> 3rd emitted tlast=1 tuser=1, stat_oversize=1; next beats suppressed until input tlast.
REQ-030 Non-last beat tkeep=64'h7FFF_FFFF_FFFF_FFFF then full last beat -> last output tuser=1, stat_err=1.
REQ-031 rst pulse after 2nd of 4 beats -> outputs zero, counters zero; following 1-beat 64-byte frame -> stat_good=1, frame_count=1.
REQ-032 CNT_WIDTH=4, 17 good frames -> frame_count holds 15.

Source files
------------

// File: rtl/cmac_rx_frame_check_if.sv
// CMAC-style AXI stream bundle without tready.
// master drives the beat, slave observes it.
interface cmac_rx_frame_check_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser
  );

  modport slave (
    input tdata, tkeep, tvalid, tlast, tuser
  );
endinterface

// File: rtl/cmac_rx_frame_check.sv
// RX frame length/error checker with one-cycle latency.
// Flags runt, oversize and errored frames on tuser[0].
module cmac_rx_frame_check #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 9600,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cmac_rx_frame_check_if.slave  s_axis,
  cmac_rx_frame_check_if.master m_axis,
  output logic                 stat_good,
  output logic                 stat_runt,
  output logic                 stat_oversize,
  output logic                 stat_err,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] bad_count
);

  if (DATA_WIDTH != 512) begin : g_bad_dw
    $error("DATA_WIDTH must be 512");
  end
  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_kw
    $error("KEEP_WIDTH*8 must equal DATA_WIDTH");
  end
  if (MAX_LEN > 65535) begin : g_bad_max
    $error("MAX_LEN must not exceed 65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    DROP  = 2'd2
  } state_t;

  localparam logic [16:0] MinLen = 17'(MIN_LEN);
  localparam logic [16:0] MaxLen = 17'(MAX_LEN);
  localparam logic [CNT_WIDTH-1:0] CntOne =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic        err_q, err_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic vld_q, vld_d;
  logic last_q, last_d;
  logic good_q, good_d;
  logic runt_q, runt_d;
  logic ovs_q, ovs_d;
  logic errp_q, errp_d;
  logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;

  logic [6:0]            beat_bytes;
  logic [16:0]           new_len;
  logic [DATA_WIDTH-1:0] data_m;
  logic                  is_runt;
  logic                  is_err;
  logic                  is_bad;

  always_comb begin
    beat_bytes = '0;
    data_m     = '0;
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      beat_bytes = beat_bytes + {6'd0, s_axis.tkeep[k]};
      if (s_axis.tkeep[k]) begin
        data_m[k*8 +: 8] = s_axis.tdata[k*8 +: 8];
      end
    end
  end

  assign new_len = {1'b0, len_q} + {10'd0, beat_bytes};
  assign is_runt = new_len < MinLen;
  assign is_err  = s_axis.tuser[0] | err_q;
  assign is_bad  = is_runt | is_err;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    err_d   = err_q;
    data_d  = '0;
    keep_d  = '0;
    user_d  = '0;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    good_d  = 1'b0;
    runt_d  = 1'b0;
    ovs_d   = 1'b0;
    errp_d  = 1'b0;
    if (s_axis.tvalid) begin
      unique case (state_q)
        IDLE, FRAME: begin
          vld_d  = 1'b1;
          data_d = data_m;
          keep_d = s_axis.tkeep;
          user_d = s_axis.tuser;
          if (new_len > MaxLen) begin
            // Truncate: close the frame now, swallow the rest.
            last_d    = 1'b1;
            user_d[0] = 1'b1;
            ovs_d     = 1'b1;
            len_d     = '0;
            err_d     = 1'b0;
            state_d   = s_axis.tlast ? IDLE : DROP;
          end else if (!s_axis.tlast) begin
            user_d[0] = 1'b0;
            len_d     = new_len[15:0];
            err_d     = err_q | ~(&s_axis.tkeep)
                      | s_axis.tuser[0];
            state_d   = FRAME;
          end else begin
            last_d    = 1'b1;
            user_d[0] = is_bad;
            good_d    = ~is_bad;
            runt_d    = is_runt;
            errp_d    = is_err;
            len_d     = '0;
            err_d     = 1'b0;
            state_d   = IDLE;
          end
        end
        DROP: begin
          if (s_axis.tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fcnt_d = fcnt_q;
    bcnt_d = bcnt_q;
    if (vld_d && last_d && !(&fcnt_q)) begin
      fcnt_d = fcnt_q + CntOne;
    end
    if (vld_d && last_d && user_d[0] && !(&bcnt_q)) begin
      bcnt_d = bcnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      good_q  <= 1'b0;
      runt_q  <= 1'b0;
      ovs_q   <= 1'b0;
      errp_q  <= 1'b0;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      good_q  <= good_d;
      runt_q  <= runt_d;
      ovs_q   <= ovs_d;
      errp_q  <= errp_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tuser  = user_q;
  assign stat_good     = good_q;
  assign stat_runt     = runt_q;
  assign stat_oversize = ovs_q;
  assign stat_err      = errp_q;
  assign frame_count   = fcnt_q;
  assign bad_count     = bcnt_q;

endmodule

// File: tb/tb_cmac_rx_frame_check.sv
// Directed bench for cmac_rx_frame_check.
// MAX_LEN=128, CNT_WIDTH=4, USER_WIDTH=2 to reach boundaries fast.
module tb_cmac_rx_frame_check;

  logic clk = 1'b0;
  logic rst;
  logic stat_good, stat_runt, stat_oversize, stat_err;
  logic [3:0] frame_count, bad_count;

  int n_run = 0;
  int n_fail = 0;

  localparam logic [63:0] KF = 64'hFFFF_FFFF_FFFF_FFFF;

  cmac_rx_frame_check_if #(
    .DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(2)
  ) s_if ();
  cmac_rx_frame_check_if #(
    .DATA_WIDTH(512), .KEEP_WIDTH(64), .USER_WIDTH(2)
  ) m_if ();

  cmac_rx_frame_check #(
    .DATA_WIDTH(512),
    .KEEP_WIDTH(64),
    .USER_WIDTH(2),
    .MIN_LEN(64),
    .MAX_LEN(128),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis(s_if),
    .m_axis(m_if),
    .stat_good(stat_good),
    .stat_runt(stat_runt),
    .stat_oversize(stat_oversize),
    .stat_err(stat_err),
    .frame_count(frame_count),
    .bad_count(bad_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0]  k,
                      input logic         l,
                      input logic [1:0]   u,
                      input logic [511:0] d);
    s_if.tvalid = 1'b1;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tuser  = u;
    s_if.tdata  = d;
    tick();
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    s_if.tkeep  = '0;
    s_if.tdata  = '0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [511:0] pat;
  logic [511:0] ones;

  initial begin
    pat  = {16{32'hA5A5_1234}};
    ones = {16{32'hFFFF_FFFF}};
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    s_if.tkeep  = '0;
    s_if.tdata  = '0;
    tick();
    tick();
    check("rst_tvalid", 512'(m_if.tvalid), 512'd0);
    check("rst_tdata", m_if.tdata, 512'd0);
    check("rst_fcnt", 512'(frame_count), 512'd0);
    check("rst_bcnt", 512'(bad_count), 512'd0);
    check("rst_good", 512'(stat_good), 512'd0);
    rst = 1'b0;

    // single full good beat, upper tuser bit passes
    send(KF, 1'b1, 2'b10, pat);
    check("t1_tvalid", 512'(m_if.tvalid), 512'd1);
    check("t1_tlast", 512'(m_if.tlast), 512'd1);
    check("t1_tuser", 512'(m_if.tuser), 512'd2);
    check("t1_tdata", m_if.tdata, pat);
    check("t1_tkeep", 512'(m_if.tkeep), 512'(KF));
    check("t1_good", 512'(stat_good), 512'd1);
    check("t1_fcnt", 512'(frame_count), 512'd1);
    idle();
    check("t1_idle_vld", 512'(m_if.tvalid), 512'd0);
    check("t1_idle_good", 512'(stat_good), 512'd0);

    // 4-byte runt, bytes 2..5 kept
    send(64'h3C, 1'b1, 2'b00, ones);
    check("t2_tuser", 512'(m_if.tuser), 512'd1);
    check("t2_runt", 512'(stat_runt), 512'd1);
    check("t2_good", 512'(stat_good), 512'd0);
    check("t2_tdata", m_if.tdata, 512'hFFFF_FFFF_0000);
    check("t2_bcnt", 512'(bad_count), 512'd1);
    check("t2_fcnt", 512'(frame_count), 512'd2);
    idle();

    // exactly MAX_LEN (128) is legal
    send(KF, 1'b0, 2'b00, pat);
    check("t3_b1_last", 512'(m_if.tlast), 512'd0);
    check("t3_b1_user", 512'(m_if.tuser), 512'd0);
    send(KF, 1'b1, 2'b00, pat);
    check("t3_b2_last", 512'(m_if.tlast), 512'd1);
    check("t3_good", 512'(stat_good), 512'd1);
    check("t3_ovs", 512'(stat_oversize), 512'd0);
    check("t3_fcnt", 512'(frame_count), 512'd3);
    idle();

    // oversize: 3rd beat truncates, 4th dropped
    send(KF, 1'b0, 2'b00, pat);
    send(KF, 1'b0, 2'b00, pat);
    send(KF, 1'b0, 2'b00, pat);
    check("t4_ovs_vld", 512'(m_if.tvalid), 512'd1);
    check("t4_ovs_last", 512'(m_if.tlast), 512'd1);
    check("t4_ovs_user", 512'(m_if.tuser), 512'd1);
    check("t4_ovs", 512'(stat_oversize), 512'd1);
    check("t4_ovs_good", 512'(stat_good), 512'd0);
    send(KF, 1'b1, 2'b00, pat);
    check("t4_drop_vld", 512'(m_if.tvalid), 512'd0);
    check("t4_drop_ovs", 512'(stat_oversize), 512'd0);
    check("t4_fcnt", 512'(frame_count), 512'd4);
    check("t4_bcnt", 512'(bad_count), 512'd2);
    send(KF, 1'b1, 2'b00, pat);
    check("t4_after_good", 512'(stat_good), 512'd1);
    check("t4_after_fcnt", 512'(frame_count), 512'd5);
    idle();

    // partial tkeep on non-last beat -> error
    send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 2'b00, pat);
    send(KF, 1'b1, 2'b00, pat);
    check("t5_user", 512'(m_if.tuser), 512'd1);
    check("t5_err", 512'(stat_err), 512'd1);
    check("t5_runt", 512'(stat_runt), 512'd0);
    check("t5_good", 512'(stat_good), 512'd0);
    check("t5_bcnt", 512'(bad_count), 512'd3);
    idle();

    // tuser error on a non-last beat
    send(KF, 1'b0, 2'b01, pat);
    check("t6_b1_user", 512'(m_if.tuser), 512'd0);
    send(KF, 1'b1, 2'b00, pat);
    check("t6_err", 512'(stat_err), 512'd1);
    check("t6_bcnt", 512'(bad_count), 512'd4);
    idle();

    // empty last beat adds 0 bytes: 64 total is good
    send(KF, 1'b0, 2'b00, pat);
    send(64'h0, 1'b1, 2'b00, pat);
    check("t7_good", 512'(stat_good), 512'd1);
    check("t7_tdata", m_if.tdata, 512'd0);
    check("t7_fcnt", 512'(frame_count), 512'd8);
    idle();

    // reset mid-frame
    send(KF, 1'b0, 2'b00, pat);
    send(KF, 1'b0, 2'b00, pat);
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    tick();
    check("t8_vld", 512'(m_if.tvalid), 512'd0);
    check("t8_tdata", m_if.tdata, 512'd0);
    check("t8_fcnt", 512'(frame_count), 512'd0);
    check("t8_bcnt", 512'(bad_count), 512'd0);
    rst = 1'b0;
    send(KF, 1'b1, 2'b00, pat);
    check("t8_good", 512'(stat_good), 512'd1);
    check("t8_fcnt1", 512'(frame_count), 512'd1);
    idle();

    // saturation of 4-bit counters
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(KF, 1'b1, 2'b00, pat);
    end
    idle();
    check("t9_fcnt_sat", 512'(frame_count), 512'd15);
    check("t9_bcnt", 512'(bad_count), 512'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
